// File: rtl/cmp_stream_unit.sv
// Pipelined signed/unsigned comparator (LT/EQ/MIN/MAX) behind a one-entry valid/ready output register.
// Optional running min/max tracker on operand a, enabled by defining CMP_TRACK_EN.
module cmp_stream_unit #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 lt_flag,
    output logic                 eq_flag,
    output logic [CNT_WIDTH-1:0] txn_cnt,
    output logic                 dbg_full
`ifdef CMP_TRACK_EN
    ,
    input  logic                 trk_clr,
    input  logic                 trk_sgn,
    output logic [WIDTH-1:0]     trk_min,
    output logic [WIDTH-1:0]     trk_max,
    output logic                 trk_vld
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [1:0] OP_LT  = 2'b00;
    localparam logic [1:0] OP_EQ  = 2'b01;
    localparam logic [1:0] OP_MIN = 2'b10;

    state_t                 state_q;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   lt_q, lt_d;
    logic                   eq_q, eq_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   accept;
    logic                   drain;

    // Handshake: a transfer happens on an edge where valid and ready are both high.
    // in_ready lets a new operand in whenever the output slot is empty or being drained.
    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    assign result   = result_q;
    assign lt_flag  = lt_q;
    assign eq_flag  = eq_q;
    assign txn_cnt  = cnt_q;
    assign dbg_full = (state_q == FULL);

    always_comb begin
        lt_d = sgn ? ($signed(a) < $signed(b)) : (a < b);
        eq_d = (a == b);
        case (op)
            OP_LT:   result_d = {{(WIDTH-1){1'b0}}, lt_d};
            OP_EQ:   result_d = {{(WIDTH-1){1'b0}}, eq_d};
            OP_MIN:  result_d = lt_d ? a : b;
            default: result_d = lt_d ? b : a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            result_q <= '0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                EMPTY: if (accept) state_q <= FULL;
                FULL:  if (drain && !accept) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
            if (accept) begin
                result_q <= result_d;
                lt_q     <= lt_d;
                eq_q     <= eq_d;
                cnt_q    <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

`ifdef CMP_TRACK_EN
    logic [WIDTH-1:0] tmin_q;
    logic [WIDTH-1:0] tmax_q;
    logic             tvld_q;
    logic             a_below_min;
    logic             a_above_max;

    assign a_below_min = trk_sgn ? ($signed(a) < $signed(tmin_q)) : (a < tmin_q);
    assign a_above_max = trk_sgn ? ($signed(a) > $signed(tmax_q)) : (a > tmax_q);

    // A clear that coincides with an accept makes that operand the first sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmin_q <= '0;
            tmax_q <= '0;
            tvld_q <= 1'b0;
        end else if (accept && (trk_clr || !tvld_q)) begin
            tmin_q <= a;
            tmax_q <= a;
            tvld_q <= 1'b1;
        end else if (trk_clr) begin
            tmin_q <= '0;
            tmax_q <= '0;
            tvld_q <= 1'b0;
        end else if (accept) begin
            if (a_below_min) tmin_q <= a;
            if (a_above_max) tmax_q <= a;
        end
    end

    assign trk_min = tmin_q;
    assign trk_max = tmax_q;
    assign trk_vld = tvld_q;
`endif

endmodule
